uart_rx_fifo: RTL and testbench

Buffered, oversampled UART receiver for the IO block. It recovers 8N1 frames from the asynchronous RX pin, validates the start and stop bits, and queues good bytes in a small first-word-fall-through FIFO so the core can drain them without losing characters. Bit timing uses the same 16-bit `divisor` convention as the existing UART: one bit lasts `divisor+1` clk cycles.

---
 rtl/uart_rx_fifo_if.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of the buffered UART: FIFO head, pop/clear controls and status.
// The core (master) pops bytes and clears errors; the receiver (slave) drives
// the head byte, fill level and status flags.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd;
    logic          clr_err;
    logic [7:0]    dout;
    logic          valid;
    logic [CW-1:0] count;
    logic          full;
    logic          busy;
    logic          overrun;
    logic          ferr;

    modport master (
        output rd,
        output clr_err,
        input  dout,
        input  valid,
        input  count,
        input  full,
        input  busy,
        input  overrun,
        input  ferr
    );

    modport slave (
        input  rd,
        input  clr_err,
        output dout,
        output valid,
        output count,
        output full,
        output busy,
        output overrun,
        output ferr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO.
// One bit lasts divisor+1 clk cycles; the start bit is confirmed at its middle,
// data and stop bits are sampled one bit period apart from there.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        RX,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchronizer and edge detect
    logic          r_rx_m;
    logic          r_rx_s;
    logic          r_rx_q;
    logic          w_start_edge;

    // Receiver FSM
    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          w_stop_good;
    logic          w_stop_bad;

    // FIFO
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Sticky error flags
    logic          r_overrun;
    logic          r_ferr;

    // Bring RX into the clk domain and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_q <= 1'b1;
        end else begin
            r_rx_m <= RX;
            r_rx_s <= r_rx_m;
            r_rx_q <= r_rx_s;
        end
    end

    // Only a fresh high-to-low transition starts a frame; a line stuck low does not.
    assign w_start_edge = !r_rx_s && r_rx_q;

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: mid-bit start check, then full-bit spaced data and stop samples.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (r_cnt == (divisor >> 1)) begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                    end else begin
                        // Glitch shorter than half a bit: not a real start bit.
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (r_cnt == divisor) begin
                    // LSB arrives first, so shifting in at the MSB leaves bit 0 at [0].
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (r_cnt == divisor) begin
                    w_state_nxt = S_IDLE;
                    w_stop_good = r_rx_s;
                    w_stop_bad  = !r_rx_s;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = bus.rd && w_valid;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign w_push  = w_stop_good && (!w_full || w_pop);
    assign w_drop  = w_stop_good && w_full && !w_pop;

    // Circular buffer storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_stop_bad) begin
                r_ferr <= 1'b1;
            end else if (bus.clr_err) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign bus.dout    = r_mem[r_rd_ptr];
    assign bus.valid   = w_valid;
    assign bus.count   = r_count;
    assign bus.full    = w_full;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.overrun = r_overrun;
    assign bus.ferr    = r_ferr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit on RX and the
// FIFO/status outputs are compared against hand-computed values.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic [15:0] divisor;
    int          checks   = 0;
    int          failures = 0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor),
        .RX      (RX),
        .bus     (bus)
    );

    // 10 ns clock; stimulus changes and sampling both happen on the falling edge.
    always #5 clk = ~clk;

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    // Drive one 8N1 frame. With pop_at_stop, rd is high for exactly the edge on
    // which the receiver samples the stop bit: (divisor>>1)+3 edges into it.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        int bl;
        int pre;
        bl  = int'(divisor) + 1;
        pre = int'(divisor >> 1) + 3;
        RX = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (bl) @(negedge clk);
        end
        RX = stop;
        if (pop_at_stop) begin
            repeat (pre) @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
            repeat (bl - pre - 1) @(negedge clk);
        end else begin
            repeat (bl) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; RX = 1'b1; divisor = 16'd9;
        bus.rd = 1'b0; bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
        checks++; if (bus.ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", bus.ferr); end
        idle(10);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h55, 1'b1, 1'b0);
        checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.valid); end
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_idle got=%b exp=0", bus.busy); end
        send_byte(8'hA3, 1'b1, 1'b0);
        checks++; if (bus.count !== CW'(2)) begin failures++; $display("FAIL b2b_count2 got=%0d exp=2", bus.count); end
        checks++; if (bus.dout !== 8'h55) begin failures++; $display("FAIL b2b_dout0 got=%h exp=55", bus.dout); end
        pop_one();
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL b2b_count_pop1 got=%0d exp=1", bus.count); end
        checks++; if (bus.dout !== 8'hA3) begin failures++; $display("FAIL b2b_dout1 got=%h exp=a3", bus.dout); end
        pop_one();
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL b2b_count_pop2 got=%0d exp=0", bus.count); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_empty got=%b exp=0", bus.valid); end
        checks++; if (bus.ferr !== 1'b0) begin failures++; $display("FAIL b2b_ferr got=%b exp=0", bus.ferr); end
        // Pop while empty must be ignored.
        pop_one();
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", bus.count); end
        idle(10);
    endtask

    task automatic test_false_start();
        // RX falls; start edge is at the 3rd rising edge, busy visible right after it.
        RX = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fs_busy_early got=%b exp=0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fs_busy_rise got=%b exp=1", bus.busy); end
        RX = 1'b1;
        // Mid-start check at edge 3+(9>>1)+1 = 8 sees the line high again.
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fs_busy_hold got=%b exp=1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fs_busy_clear got=%b exp=0", bus.busy); end
        idle(20);
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL fs_count got=%0d exp=0", bus.count); end
        checks++; if (bus.ferr !== 1'b0 || bus.overrun !== 1'b0) begin failures++; $display("FAIL fs_flags got=%b%b exp=00", bus.ferr, bus.overrun); end
    endtask

    task automatic test_frame_error();
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(10);
        checks++; if (bus.ferr !== 1'b1) begin failures++; $display("FAIL fe_ferr got=%b exp=1", bus.ferr); end
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL fe_count got=%0d exp=0", bus.count); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL fe_overrun got=%b exp=0", bus.overrun); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++; if (bus.ferr !== 1'b0) begin failures++; $display("FAIL fe_clr got=%b exp=0", bus.ferr); end
        send_byte(8'h81, 1'b1, 1'b0);
        checks++; if (bus.dout !== 8'h81) begin failures++; $display("FAIL fe_next_dout got=%h exp=81", bus.dout); end
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL fe_next_count got=%0d exp=1", bus.count); end
        checks++; if (bus.ferr !== 1'b0) begin failures++; $display("FAIL fe_next_ferr got=%b exp=0", bus.ferr); end
        pop_one();
        idle(10);
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ov_full4 got=%b exp=1", bus.full); end
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ov_none_yet got=%b exp=0", bus.overrun); end
        send_byte(8'h05, 1'b1, 1'b0);
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ov_full got=%b exp=1", bus.full); end
        checks++; if (bus.count !== CW'(4)) begin failures++; $display("FAIL ov_count got=%0d exp=4", bus.count); end
        checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ov_flag got=%b exp=1", bus.overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            checks++; if (bus.dout !== exp_b) begin failures++; $display("FAIL ov_drain%0d got=%h exp=%h", i, bus.dout, exp_b); end
            pop_one();
        end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL ov_empty got=%b exp=0", bus.valid); end
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ov_clr got=%b exp=0", bus.overrun); end
        idle(10);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        send_byte(8'h05, 1'b1, 1'b1);
        checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL pp_overrun got=%b exp=0", bus.overrun); end
        checks++; if (bus.count !== CW'(4)) begin failures++; $display("FAIL pp_count got=%0d exp=4", bus.count); end
        for (int i = 2; i <= 5; i++) begin
            exp_b = 8'(i);
            checks++; if (bus.dout !== exp_b) begin failures++; $display("FAIL pp_drain%0d got=%h exp=%h", i, bus.dout, exp_b); end
            pop_one();
        end
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL pp_count_end got=%0d exp=0", bus.count); end
        idle(10);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        send_byte(8'h99, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(10);
        checks++; if (bus.count !== CW'(1) || bus.ferr !== 1'b1) begin failures++; $display("FAIL rm_pre got=count%0d,ferr%b exp=count1,ferr1", bus.count, bus.ferr); end
        b = 8'h5A;
        RX = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = b[i];
            repeat (10) @(negedge clk);
        end
        RX = b[4];
        repeat (5) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rm_busy_mid got=%b exp=1", bus.busy); end
        rst = 1'b1;
        RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL rm_dout got=%h exp=00", bus.dout); end
        checks++; if (bus.valid !== 1'b0 || bus.count !== CW'(0) || bus.full !== 1'b0) begin failures++; $display("FAIL rm_fifo got=v%b,c%0d,f%b exp=v0,c0,f0", bus.valid, bus.count, bus.full); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ferr !== 1'b0 || bus.overrun !== 1'b0) begin failures++; $display("FAIL rm_flags got=%b%b exp=00", bus.ferr, bus.overrun); end
        idle(10);
        send_byte(8'h7E, 1'b1, 1'b0);
        checks++; if (bus.dout !== 8'h7E) begin failures++; $display("FAIL rm_next_dout got=%h exp=7e", bus.dout); end
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL rm_next_count got=%0d exp=1", bus.count); end
        pop_one();
        idle(10);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
